// File: rtl/alsu_cmd_sequencer.sv
// Command FIFO and issue sequencer feeding the registered ALSU control pins.
// Each popped command holds its fields on the pins for rep+1 consecutive cycles.
module alsu_cmd_sequencer #(
    parameter int    DEPTH        = 4,
    parameter string DROP_INVALID = "OFF"
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [18:0]                cmd_in,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       hold,
    output logic [2:0]                 a,
    output logic [2:0]                 b,
    output logic [2:0]                 op,
    output logic                       cin,
    output logic                       serial_in,
    output logic                       dir,
    output logic                       red_op_a,
    output logic                       red_op_b,
    output logic                       bypass_a,
    output logic                       bypass_b,
    output logic                       issue_valid,
    output logic                       invalid_cmd,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 issued_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam bit DROP_EN = (DROP_INVALID == "ON");

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [0:0]  state_q, state_d;
    logic [2:0]  rep_cnt_q, rep_cnt_d;
    logic [15:0] pins_q, pins_d;
    logic        issue_valid_q, issue_valid_d;
    logic        invalid_q, invalid_d;
    logic [7:0]  issued_q, issued_d;

    logic        wr_en;
    logic        decide;
    logic        pop;
    logic [18:0] head;
    logic        head_invalid;

    assign cmd_ready = (count_q < CW'(DEPTH)) && !rst;
    assign wr_en     = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Invalid unless a bypass is set: opcodes 110/111 always, reductions only with AND/XOR.
    assign head_invalid = !head[1] && !head[0] &&
                          ((head[9:8] == 2'b11) || ((head[3] | head[2]) && (head[9:8] != 2'b00)));

    assign decide = (state_q == IDLE) || (rep_cnt_q == '0);
    assign pop    = decide && (count_q != '0) && !hold;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        rep_cnt_d     = rep_cnt_q;
        pins_d        = pins_q;
        issue_valid_d = issue_valid_q;
        invalid_d     = 1'b0;
        issued_d      = issued_q;
        if (decide) begin
            if (pop) begin
                invalid_d = head_invalid;
                // A dropped command occupies one idle-looking cycle; IDLE re-decides next edge.
                if (head_invalid && DROP_EN) begin
                    state_d       = IDLE;
                    rep_cnt_d     = '0;
                    pins_d        = '0;
                    issue_valid_d = 1'b0;
                end else begin
                    state_d       = ISSUE;
                    rep_cnt_d     = head[18:16];
                    pins_d        = head[15:0];
                    issue_valid_d = 1'b1;
                    issued_d      = issued_q + 8'd1;
                end
            end else begin
                state_d       = IDLE;
                rep_cnt_d     = '0;
                pins_d        = '0;
                issue_valid_d = 1'b0;
            end
        end else begin
            rep_cnt_d = rep_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rep_cnt_q     <= '0;
            pins_q        <= '0;
            issue_valid_q <= 1'b0;
            invalid_q     <= 1'b0;
            issued_q      <= '0;
        end else begin
            state_q       <= state_d;
            rep_cnt_q     <= rep_cnt_d;
            pins_q        <= pins_d;
            issue_valid_q <= issue_valid_d;
            invalid_q     <= invalid_d;
            issued_q      <= issued_d;
        end
    end

    assign {a, b, op, cin, serial_in, dir, red_op_a, red_op_b, bypass_a, bypass_b} = pins_q;
    assign issue_valid  = issue_valid_q;
    assign invalid_cmd  = invalid_q;
    assign fifo_count   = count_q;
    assign issued_count = issued_q;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Scoreboard bench: accepted commands expand into expected per-cycle pin records,
// which a monitor pops whenever the sequencer shows a live or invalid cycle.
module tb_alsu_cmd_sequencer;

    localparam int    DEPTH      = 4;
    localparam string TB_DROP    = "ON";
    localparam bit    TB_DROP_EN = (TB_DROP == "ON");

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] cmd_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        hold;
    logic [2:0]  a, b, op;
    logic        cin, serial_in, dir, red_op_a, red_op_b, bypass_a, bypass_b;
    logic        issue_valid;
    logic        invalid_cmd;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]  issued_count;

    alsu_cmd_sequencer #(.DEPTH(DEPTH), .DROP_INVALID(TB_DROP)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .hold(hold), .a(a), .b(b), .op(op), .cin(cin), .serial_in(serial_in), .dir(dir),
        .red_op_a(red_op_a), .red_op_b(red_op_b), .bypass_a(bypass_a), .bypass_b(bypass_b),
        .issue_valid(issue_valid), .invalid_cmd(invalid_cmd), .fifo_count(fifo_count),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pins;
        logic        iv;
        logic        inv;
        logic [7:0]  issued;
        logic        first;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   inv_cyc  = -1;
    int   inv_pulses = 0;
    int   acc_cyc  = 0;
    int   model_issued = 0;
    bit   mid_cmd  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a command is illegal without bypass if op is 6/7, or a reduction is
    // requested for an op other than AND(0)/XOR(1).
    function automatic bit is_invalid(input logic [18:0] w);
        int opv;
        opv = int'(w[9:7]);
        if (w[1] || w[0]) return 0;
        if (opv >= 6) return 1;
        if ((w[3] || w[2]) && opv > 1) return 1;
        return 0;
    endfunction

    task automatic model_push(input logic [18:0] w);
        exp_t e;
        int   rep;
        bit   bad;
        rep = int'(w[18:16]);
        bad = is_invalid(w);
        if (bad && TB_DROP_EN) begin
            e = '{pins: 16'h0, iv: 1'b0, inv: 1'b1, issued: 8'(model_issued), first: 1'b1, last: 1'b1};
            exp_q.push_back(e);
        end else begin
            model_issued = (model_issued + 1) % 256;
            for (int k = 0; k <= rep; k++) begin
                e = '{pins: w[15:0], iv: 1'b1, inv: (bad && k == 0), issued: 8'(model_issued),
                      first: (k == 0), last: (k == rep)};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic put(input logic [18:0] w, output bit acc);
        @(negedge clk);
        cmd_in    = w;
        cmd_valid = 1'b1;
        acc       = cmd_ready;
        @(posedge clk);
        if (acc) begin
            model_push(w);
            acc_cyc = cyc;
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic put_retry(input logic [18:0] w, output bit acc);
        acc = 0;
        for (int t = 0; t < 50 && !acc; t++) put(w, acc);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_count == '0 && !issue_valid) break;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_issued = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one record per live/invalid cycle; idle cycles must show zero pins.
    initial begin
        exp_t        e;
        logic [15:0] pins;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            pins = {a, b, op, cin, serial_in, dir, red_op_a, red_op_b, bypass_a, bypass_b};
            if (rst) begin
                mid_cmd = 0;
            end else if (issue_valid || invalid_cmd) begin
                if (invalid_cmd) begin
                    inv_pulses++;
                    inv_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {issue_valid, invalid_cmd}, 2'b00);
                    mid_cmd = 0;
                end else begin
                    e = exp_q.pop_front();
                    check("issue_cycle", {issue_valid, invalid_cmd, issued_count, pins},
                          {e.iv, e.inv, e.issued, e.pins});
                    if (e.first && e.iv) starts.push_back(cyc);
                    mid_cmd = !e.last;
                end
            end else begin
                if (mid_cmd) check("gap_in_cmd", issue_valid, 1'b1);
                mid_cmd = 0;
                check("idle_pins_zero", pins, 16'h0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          nacc;
        int          p0;
        logic [18:0] w;
        logic [2:0]  rep;

        rst = 1'b1; cmd_in = '0; cmd_valid = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pins", {a, b, op, cin, serial_in, dir, red_op_a, red_op_b, bypass_a, bypass_b}, 16'h0);
        check("rst_issue_valid", {issue_valid, invalid_cmd}, 2'b00);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_issued_count", issued_count, 0);
        check("rst_cmd_ready", cmd_ready, 1'b0);

        // Single command accepted on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", cmd_ready, 1'b1);
        cmd_in = 19'h0_5C80; cmd_valid = 1'b1;
        @(posedge clk);
        model_push(19'h0_5C80);
        acc_cyc = cyc;
        starts.delete();
        #1 cmd_valid = 1'b0;
        drain(50);
        check("single_latency", (starts.size() > 0) ? starts[0] - acc_cyc : -1, 2);
        check("single_issued", issued_count, 8'd1);

        // Repeat 3: op=100, dir=1.
        put({3'd3, 3'd5, 3'd6, 3'b100, 1'b0, 1'b1, 1'b1, 4'b0000}, acc);
        drain(50);

        // Back-pressure with hold, then a gap-free burst.
        hold = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            put({3'd0, 3'(i), 3'(7 - i), 3'(i % 3), 7'b0100000}, acc);
            nacc += int'(acc);
        end
        check("full_accepted", nacc, 4);
        check("full_fifo_count", fifo_count, 4);
        check("full_cmd_ready", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_no_issue", issue_valid, 1'b0);
        starts.delete();
        hold = 1'b0;
        drain(50);
        check("burst_count", starts.size(), 4);
        check("burst_no_gap", (starts.size() >= 4) ? starts[3] - starts[0] : -1, 3);

        // Invalid command (reduction with op 011) followed by a valid one.
        hold = 1'b1;
        put({3'd2, 3'd1, 3'd2, 3'b011, 7'b0001000}, acc);
        put(19'h0_5C80, acc);
        starts.delete();
        p0 = inv_pulses;
        hold = 1'b0;
        drain(50);
        check("invalid_pulses", inv_pulses - p0, 1);
        check("invalid_next_start", (starts.size() > 0) ? starts[0] - inv_cyc : -1, TB_DROP_EN ? 1 : 0);

        // Reset during cycle 2 of a rep=5 command with two words queued.
        put({3'd5, 3'd3, 3'd4, 3'b010, 7'b0000010}, acc);
        put({3'd0, 3'd1, 3'd1, 3'b000, 7'b0000001}, acc);
        put({3'd0, 3'd2, 3'd2, 3'b001, 7'b0000001}, acc);
        @(negedge clk);
        check("pre_rst_fifo_count", fifo_count, 2);
        rst = 1'b1;
        exp_q.delete();
        model_issued = 0;
        #1;
        check("midrst_pins", {issue_valid, a, b, op, cin, serial_in, dir, red_op_a, red_op_b, bypass_a, bypass_b}, 17'h0);
        check("midrst_fifo_count", fifo_count, 0);
        check("midrst_issued", issued_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_fifo_count", fifo_count, 0);
        check("post_rst_issued", issued_count, 0);

        // Randomised traffic with random hold.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                rep = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
                w = {rep, 16'($urandom)};
                put(w, acc);
            end else begin
                @(negedge clk);
            end
            hold = ($urandom_range(0, 4) == 0);
        end
        hold = 1'b0;
        drain(3000);

        // 256 issued commands wrap the counter back to zero.
        do_reset();
        nacc = 0;
        for (int i = 0; i < 256; i++) begin
            w = {3'd0, 16'($urandom) | 16'h0002};
            put_retry(w, acc);
            nacc += int'(acc);
        end
        drain(200);
        check("wrap_accepted", nacc, 256);
        check("wrap_issued_count", issued_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
